// File: rtl/fifo_tx_serializer_if.sv
// rtl/fifo_tx_serializer_if.sv - FIFO show-ahead read-port bundle between a FIFO and its serializer
//
// Purpose: groups the read-side handshake of the synchronous FIFO so the
// serializer and whatever feeds it share one set of wires.
// Signals:
//   en     1         consumer enable (driven by the feeding side)
//   empty  1         FIFO empty flag
//   dIn    BITWIDTH  show-ahead read data, valid whenever empty=0
//   rEn    1         pop strobe from the consumer
// Modports:
//   master - the FIFO / feeding side (drives en, empty, dIn; sees rEn)
//   slave  - the serializer (sees en, empty, dIn; drives rEn)
interface fifo_tx_serializer_if #(
  parameter int BITWIDTH = 5
);
  logic                en;
  logic                empty;
  logic [BITWIDTH-1:0] dIn;
  logic                rEn;

  modport master (
    output en,
    output empty,
    output dIn,
    input  rEn
  );

  modport slave (
    input  en,
    input  empty,
    input  dIn,
    output rEn
  );
endinterface

// File: rtl/fifo_tx_serializer.sv
// rtl/fifo_tx_serializer.sv - pops FIFO words and sends each as an async serial frame
//
// Purpose: read-side consumer of the synchronous FIFO. Each popped word goes
// out as start bit, data LSB-first, optional even parity, then STOP_BITS stop
// bits, every bit lasting CLKS_PER_BIT clocks. Back-to-back frames need no
// idle gap: the next word is captured in the final stop-bit cycle.
// Ports:
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   fifo       if   slave side of the FIFO read port (en, empty, dIn, rEn)
//                   rEn is combinational and high only in a capture cycle
//   txOut      out  serial line, idles high (registered)
//   busy       out  high from the first start-bit cycle to the last stop-bit cycle (registered)
//   frameDone  out  high only in the final cycle of the last stop bit (registered)
module fifo_tx_serializer #(
  parameter int BITWIDTH     = 5,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  fifo_tx_serializer_if.slave       fifo,
  output logic                      txOut,
  output logic                      busy,
  output logic                      frameDone
);

  // Counter widths carry one spare bit so the terminal values always fit.
  localparam int W_BAUD = $clog2(CLKS_PER_BIT) + 1;
  localparam int W_IDX  = $clog2(BITWIDTH) + 1;

  localparam logic [W_BAUD-1:0] BAUD_LAST      = W_BAUD'(CLKS_PER_BIT - 1);
  localparam logic [W_IDX-1:0]  IDX_LAST_DATA  = W_IDX'(BITWIDTH - 1);
  localparam logic [W_IDX-1:0]  IDX_LAST_STOP  = W_IDX'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state;
  state_t              stateNext;
  logic [W_BAUD-1:0]   baudCnt;
  logic [W_BAUD-1:0]   baudNext;
  logic [W_IDX-1:0]    bitIdx;
  logic [W_IDX-1:0]    bitIdxNext;
  logic [BITWIDTH-1:0] shiftReg;
  logic [BITWIDTH-1:0] shiftNext;
  logic                parityReg;
  logic                parityNext;

  logic                txOutNext;
  logic                busyNext;
  logic                frameDoneNext;

  logic                popOk;
  logic                baudLast;
  logic                lastStopCycle;
  logic                capture;

  // Pop points are only IDLE and the very last stop-bit cycle; en/empty are
  // ignored everywhere else so a started frame always runs to completion.
  assign popOk         = fifo.en & ~fifo.empty & ~rst;
  assign baudLast      = (baudCnt == BAUD_LAST);
  assign lastStopCycle = (state == STOP) && baudLast && (bitIdx == IDX_LAST_STOP);
  assign capture       = popOk & ((state == IDLE) | lastStopCycle);
  assign fifo.rEn      = capture;

  // Next-state and counter logic.
  always_comb begin
    stateNext  = state;
    baudNext   = baudCnt;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    parityNext = parityReg;

    case (state)
      IDLE: begin
        baudNext   = '0;
        bitIdxNext = '0;
      end

      START: begin
        if (baudLast) begin
          baudNext   = '0;
          bitIdxNext = '0;
          stateNext  = DATA;
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end

      DATA: begin
        if (baudLast) begin
          baudNext  = '0;
          shiftNext = shiftReg >> 1;
          if (bitIdx == IDX_LAST_DATA) begin
            bitIdxNext = '0;
            stateNext  = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bitIdxNext = bitIdx + 1'b1;
          end
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end

      PARITY: begin
        if (baudLast) begin
          baudNext   = '0;
          bitIdxNext = '0;
          stateNext  = STOP;
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end

      STOP: begin
        if (baudLast) begin
          baudNext = '0;
          if (bitIdx == IDX_LAST_STOP) begin
            bitIdxNext = '0;
            stateNext  = IDLE;
          end else begin
            bitIdxNext = bitIdx + 1'b1;
          end
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end

      default: begin
        stateNext  = IDLE;
        baudNext   = '0;
        bitIdxNext = '0;
      end
    endcase

    // A capture overrides whatever the state logic chose: it can only occur
    // in IDLE or the last stop cycle, and both lead straight into START.
    if (capture) begin
      shiftNext  = fifo.dIn;
      parityNext = ^fifo.dIn;
      stateNext  = START;
      baudNext   = '0;
      bitIdxNext = '0;
    end
  end

  // Registered outputs are precomputed from the next state so that they line
  // up with the state they describe rather than trailing it by a cycle.
  always_comb begin
    txOutNext     = 1'b1;
    busyNext      = (stateNext != IDLE);
    frameDoneNext = (stateNext == STOP) && (baudNext == BAUD_LAST) &&
                    (bitIdxNext == IDX_LAST_STOP);
    case (stateNext)
      START:   txOutNext = 1'b0;
      DATA:    txOutNext = shiftNext[0];
      PARITY:  txOutNext = parityNext;
      default: txOutNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baudCnt   <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      parityReg <= 1'b0;
      txOut     <= 1'b1;
      busy      <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      state     <= stateNext;
      baudCnt   <= baudNext;
      bitIdx    <= bitIdxNext;
      shiftReg  <= shiftNext;
      parityReg <= parityNext;
      txOut     <= txOutNext;
      busy      <= busyNext;
      frameDone <= frameDoneNext;
    end
  end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// tb/tb_fifo_tx_serializer.sv - self-checking bench for fifo_tx_serializer
module tb_fifo_tx_serializer;
  localparam int BW    = 5;
  localparam int CPB   = 4;
  localparam int PAR   = 1;
  localparam int STOPB = 1;
  localparam int FRAME = (1 + BW + PAR + STOPB) * CPB;

  // Slot values of the 5'b10110 frame, slot s at bit s: 0,0,1,1,0,1,1,1
  localparam logic [7:0] SLOTS_10110 = 8'b1110_1100;

  logic clk;
  logic rst;
  logic txOut;
  logic busy;
  logic frameDone;

  fifo_tx_serializer_if #(.BITWIDTH(BW)) ifc ();

  fifo_tx_serializer #(
    .BITWIDTH    (BW),
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (PAR),
    .STOP_BITS   (STOPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fifo     (ifc.slave),
    .txOut    (txOut),
    .busy     (busy),
    .frameDone(frameDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stimulus FIFO (show-ahead): head word is presented whenever non-empty.
  logic [BW-1:0] q[$];

  task automatic applyFifo();
    ifc.empty = (q.size() == 0);
    ifc.dIn   = (q.size() != 0) ? q[0] : '0;
  endtask

  // Per-tick logs: renLog[i] is rEn in the cycle before edge i, the other
  // logs hold the outputs in the cycle after edge i.
  bit renLog[$];
  bit txLog[$];
  bit busyLog[$];
  bit doneLog[$];

  task automatic clearLogs();
    renLog.delete();
    txLog.delete();
    busyLog.delete();
    doneLog.delete();
  endtask

  task automatic tick();
    bit renPre;
    logic [BW-1:0] popped;
    #2;
    renPre = ifc.rEn;
    @(posedge clk);
    #1;
    if (renPre && q.size() != 0) popped = q.pop_front();
    applyFifo();
    renLog.push_back(renPre);
    txLog.push_back(txOut);
    busyLog.push_back(busy);
    doneLog.push_back(frameDone);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int countOnes(input bit v[$]);
    int c = 0;
    foreach (v[i]) c += v[i];
    return c;
  endfunction

  // Behavioural model: a frame is a list of line levels, one per clock,
  // built directly from the word; pos is the cycle within it (-1 = idle).
  bit  frameBits[FRAME];
  int  pos = -1;

  function automatic void buildFrame(input logic [BW-1:0] w);
    for (int c = 0; c < FRAME; c++) begin
      int b;
      b = c / CPB;
      if (b == 0)                   frameBits[c] = 1'b0;
      else if (b <= BW)             frameBits[c] = w[b-1];
      else if (PAR != 0 && b == BW + 1) frameBits[c] = ^w;
      else                          frameBits[c] = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    bit expREn;
    expREn = !rst && ifc.en && !ifc.empty && (pos < 0 || pos == FRAME - 1);
    chk("rEn",       int'(ifc.rEn),  int'(expREn));
    chk("txOut",     int'(txOut),    (pos < 0) ? 1 : int'(frameBits[pos]));
    chk("busy",      int'(busy),     int'(pos >= 0));
    chk("frameDone", int'(frameDone), int'(pos == FRAME - 1));
    if (rst) begin
      pos = -1;
    end else if (expREn) begin
      buildFrame(ifc.dIn);
      pos = 0;
    end else if (pos >= 0) begin
      pos++;
      if (pos == FRAME) pos = -1;
    end
  end

  initial begin
    rst    = 1'b1;
    ifc.en = 1'b1;
    q.push_back(5'h1F);
    applyFifo();
    #6;

    // 1: reset held three cycles with a word available
    clearLogs();
    ticks(3);
    chk("t1_rEn_count",  countOnes(renLog),  0);
    chk("t1_busy_count", countOnes(busyLog), 0);
    chk("t1_done_count", countOnes(doneLog), 0);
    chk("t1_tx_ones",    countOnes(txLog),   3);
    q.delete();
    applyFifo();
    rst = 1'b0;
    ticks(2);

    // 2: single word 5'b10110
    clearLogs();
    q.push_back(5'b10110);
    applyFifo();
    ticks(40);
    chk("t2_rEn_count",  countOnes(renLog),  1);
    chk("t2_rEn_first",  int'(renLog[0]),    1);
    chk("t2_busy_count", countOnes(busyLog), FRAME);
    chk("t2_busy_last",  int'(busyLog[31]),  1);
    chk("t2_busy_after", int'(busyLog[32]),  0);
    chk("t2_done_count", countOnes(doneLog), 1);
    chk("t2_done_at32",  int'(doneLog[31]),  1);
    for (int s = 0; s < 8; s++)
      chk($sformatf("t2_slot%0d", s), int'(txLog[4*s+2]), int'(SLOTS_10110[s]));

    // 3: back-to-back 5'h1F then 5'h00
    clearLogs();
    q.push_back(5'h1F);
    q.push_back(5'h00);
    applyFifo();
    ticks(72);
    chk("t3_rEn_count",   countOnes(renLog),  2);
    chk("t3_rEn_second",  int'(renLog[32]),   1);
    chk("t3_done_first",  int'(doneLog[31]),  1);
    chk("t3_start2",      int'(txLog[32]),    0);
    chk("t3_parity1",     int'(txLog[26]),    1);
    chk("t3_parity2",     int'(txLog[58]),    0);
    chk("t3_busy_count",  countOnes(busyLog), 2 * FRAME);
    chk("t3_busy_63",     int'(busyLog[63]),  1);
    chk("t3_busy_64",     int'(busyLog[64]),  0);

    // 4: empty FIFO with en=1
    clearLogs();
    ticks(100);
    chk("t4_rEn_count",  countOnes(renLog),  0);
    chk("t4_busy_count", countOnes(busyLog), 0);
    chk("t4_tx_ones",    countOnes(txLog),   100);

    // 5: reset at cycle 10 of a frame
    clearLogs();
    q.push_back(5'b01001);
    applyFifo();
    ticks(10);
    rst = 1'b1;
    q.push_back(5'b00111);
    applyFifo();
    tick();
    chk("t5_tx_after_rst",   int'(txLog[10]),  1);
    chk("t5_busy_after_rst", int'(busyLog[10]), 0);
    tick();
    chk("t5_no_rEn_in_rst",  int'(renLog[10]) + int'(renLog[11]), 0);
    rst = 1'b0;
    ticks(36);
    chk("t5_rEn_release",  int'(renLog[12]),  1);
    chk("t5_start_new",    int'(txLog[12]),   0);
    chk("t5_done_new",     int'(doneLog[43]), 1);
    chk("t5_q_drained",    q.size(),          0);

    // 6: en dropped mid-frame with more words queued
    clearLogs();
    q.push_back(5'h15);
    q.push_back(5'h0A);
    applyFifo();
    ticks(5);
    ifc.en = 1'b0;
    ticks(40);
    chk("t6_rEn_count",  countOnes(renLog),  1);
    chk("t6_busy_count", countOnes(busyLog), FRAME);
    chk("t6_done_at32",  int'(doneLog[31]),  1);
    chk("t6_no_rEn_done", int'(renLog[32]),  0);
    chk("t6_idle_end",   int'(busyLog[44]),  0);
    chk("t6_q_left",     q.size(),           1);
    ifc.en = 1'b1;
    ticks(36);
    chk("t6_q_drained",  q.size(),           0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
